// File: rtl/sum_accumulator.sv
// Frame accumulator for the operand adder's sums: adds N_SAMPLES sums into a
// saturating total and holds it on a valid/ready output until it is taken.
module sum_accumulator #(
  parameter int IN_W      = 5,
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [IN_W-1:0]  MAX_SUM  = IN_W'(2 * ((1 << (IN_W - 1)) - 1));

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sat_acc;
  logic             sat_ovf;

  // One extra bit catches the carry out; anything beyond ACC_W bits clamps.
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
  assign sat_acc = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign sat_ovf = ovf_q | sum_w[ACC_W];

  assign in_ready  = (state_q == ACCUM) && !clear;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      ovf_d       = 1'b0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d = sat_acc;
            ovf_d = sat_ovf;
            if (count_q == CNT_LAST) begin
              count_d     = '0;
              out_acc_d   = sat_acc;
              out_ovf_d   = sat_ovf;
              out_valid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Previous-cycle stall snapshot, used only by the stability self-check.
  logic             stall_q;
  logic [ACC_W-1:0] acc_prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q    <= 1'b0;
      acc_prev_q <= '0;
    end else begin
      stall_q    <= out_valid_q && !out_ready;
      acc_prev_q <= out_acc_q;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid) assert (in_sum <= MAX_SUM) else $error("in_sum out of range");
      if (state_q == HOLD) assert (!in_ready) else $error("in_ready high in HOLD");
      if (stall_q) assert (out_acc_q == acc_prev_q) else $error("out_acc changed under stall");
      assert ({1'b0, count_q} < (CNT_W + 1)'(N_SAMPLES)) else $error("count out of range");
    end
  end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
Downstream consumer of the 4-bit operand adder's 5-bit sum. It accepts one sum per valid/ready handshake and accumulates N_SAMPLES sums into a saturating accumulator. It then presents the total on a valid/ready output port and holds it until the output is taken. Immediate assertions inside the block check its input range and handshake invariants, in the same style as the adder's self-checks.

Parameters:
IN_W, 5, width of incoming sum (4-bit + 4-bit adder output; legal max value 30)
N_SAMPLES, 4, sums per accumulation frame (>=2)
ACC_W, 8, accumulator/output width; result clamps to 2^ACC_W-1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame abort; highest priority after reset
in_valid  input  1  upstream sum valid
in_ready  output  1  block can accept a sum this cycle
in_sum  input  IN_W  sum from adder stage
out_valid  output  1  out_acc/out_ovf hold a completed frame
out_ready  input  1  downstream takes the frame
out_acc  output  ACC_W  frame total (saturated)
out_ovf  output  1  frame total exceeded 2^ACC_W-1 and was clamped

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, count=0, out_valid=0, out_acc=0, out_ovf=0. in_ready reads 1 while in ACCUM, but nothing is accepted while rst_n is low.
- in_ready = (state==ACCUM) && !clear; combinational. Accept = in_valid && in_ready.
- ACCUM state:
  - On accept: acc_next = acc + zero-extended in_sum, computed at ACC_W+1 bits.
  - If the ACC_W+1-bit result exceeds 2^ACC_W-1: acc = 2^ACC_W-1 and the sticky ovf bit is set. Otherwise acc = result.
  - count increments on each accept.
  - If the accept has count==N_SAMPLES-1: next cycle out_acc=final acc, out_ovf=sticky ovf (including this sample), out_valid=1, state=HOLD, count=0.
  - Latency: out_valid rises exactly 1 cycle after the N_SAMPLES-th accept.
- HOLD state:
  - in_ready=0.
  - out_acc/out_ovf/out_valid stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: next cycle out_valid=0, acc=0, ovf=0, state=ACCUM. No input is accepted in the cycle the output is taken, so there is a minimum 1-cycle bubble between frames.
- No accept while in_valid=0: state and acc hold, with no timeout.
- clear=1 (any state): next cycle acc=0, count=0, ovf=0, out_valid=0, state=ACCUM. A pending HOLD frame is discarded. A sample presented with clear is not accepted. out_acc/out_ovf hold their last values and are meaningless while out_valid=0.
- Reset mid-frame: partial acc is discarded immediately (asynchronously), and there is no output for that frame.
- Immediate assertions (always block, $error on fail):
  - in_valid -> in_sum <= 30.
  - state==HOLD -> !in_ready.
  - out_valid && !out_ready held from the previous cycle -> out_acc unchanged.
  - count < N_SAMPLES.

Test Plan:
- Reset, then in_valid with sums 3,7,10,5 on consecutive cycles, out_ready=1 -> out_valid one cycle after 4th accept with out_acc=25, out_ovf=0; out_valid drops next cycle, in_ready=1 after.
- Sums 30,30,30,30, ACC_W=8 -> out_acc=120, out_ovf=0. Same with ACC_W=6 -> out_acc=63, out_ovf=1, no wraparound.
- Frame 1,2,3,4 completes with out_ready=0 for 5 cycles -> out_acc=10 stable, in_ready=0 throughout, extra in_valid ignored. Raise out_ready -> frame taken, next frame starts clean at 0.
- Gapped input: sums 2 (cycle 0), gap 3 cycles, 4, 6, gap, 8 -> out_acc=20, emitted 1 cycle after the sum 8 is accepted.
- Two accepts (5,5), then clear=1 with in_valid=1, in_sum=9 -> 9 not accepted. Next frame 1,1,1,1 -> out_acc=4. Also assert clear during HOLD -> out_valid drops next cycle, frame lost.
- Three accepts, then rst_n pulsed low mid-cycle -> out_valid/out_acc/out_ovf immediately 0. After release, 4 sums of 1 -> out_acc=4; no assertion failures in any scenario.
